// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states, next-PC sources
// and the instruction size used for sequential fetch.
package pc_pkg;

    typedef enum logic {
        PC_BUBBLE,
        PC_RUN
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JAL,
        SRC_JALR,
        SRC_REDIR
    } pc_src_e;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC target selection: computes sequential, branch/JAL and JALR
// targets, resolves them by priority and masks to the implemented space.
// With PC_UNIT_MISALIGN_TRAP_EN defined the raw target and a bit1
// misalignment flag are exported; otherwise bit1 of control targets is
// silently cleared here.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 16
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            run,
    input  logic            br_en,
    input  logic            br_cond,
    input  logic            jal,
    input  logic            jalr,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
`ifdef PC_UNIT_MISALIGN_TRAP_EN
    output logic [XLEN-1:0] raw_target,
    output logic            tgt_mis,
`endif
    output pc_src_e         src
);

    localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} >> (XLEN - ADDR_BITS);
    localparam logic [XLEN-1:0] CLR_B0    = ~XLEN'(1);
    localparam logic [XLEN-1:0] CLR_B1    = ~XLEN'(2);
    localparam logic [XLEN-1:0] CLR_B10   = ~XLEN'(3);

    // Drop address bits above the implemented PC width.
    function automatic logic [XLEN-1:0] mask_addr(input logic [XLEN-1:0] a);
        return a & ADDR_MASK;
    endfunction

    logic signed [XLEN-1:0] imm_s;
    logic [XLEN-1:0]        seq_tgt;
    logic [XLEN-1:0]        rel_tgt;
    logic [XLEN-1:0]        jalr_tgt;
    logic [XLEN-1:0]        raw;
    logic                   ctrl_src;

    assign imm_s    = imm;
    assign seq_tgt  = pc + XLEN'(INSN_BYTES);
    assign rel_tgt  = pc + $unsigned(imm_s);
    assign jalr_tgt = (rs1_data + $unsigned(imm_s)) & CLR_B0;
    assign pc_plus4 = mask_addr(seq_tgt);

    // Priority mux: redirect > jalr > jal > taken branch > sequential;
    // control strobes only count while an instruction is live.
    always_comb begin
        src = SRC_SEQ;
        raw = seq_tgt;
        if (redirect) begin
            src = SRC_REDIR;
            raw = redirect_pc & CLR_B10;
        end else if (run) begin
            if (jalr) begin
                src = SRC_JALR;
                raw = jalr_tgt;
            end else if (jal) begin
                src = SRC_JAL;
                raw = rel_tgt;
            end else if (br_en && br_cond) begin
                src = SRC_BR;
                raw = rel_tgt;
            end
        end
    end

    assign ctrl_src = (src == SRC_BR) || (src == SRC_JAL) || (src == SRC_JALR);

`ifdef PC_UNIT_MISALIGN_TRAP_EN
    assign raw_target = raw;
    assign tgt_mis    = ctrl_src && raw[1];
    assign next_pc    = mask_addr(raw);
`else
    assign next_pc    = ctrl_src ? (mask_addr(raw) & CLR_B1) : mask_addr(raw);
`endif

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, BUBBLE/RUN FSM, retire counter and
// optional misaligned-target trap (enable with PC_UNIT_MISALIGN_TRAP_EN).
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ADDR_BITS = 16,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_en,
    input  logic             br_cond,
    input  logic             jal,
    input  logic             jalr,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_valid,
    output logic             taken,
    output logic             misalign,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} >> (XLEN - ADDR_BITS);
    localparam logic [XLEN-1:0] RST_PC    = RESET_VEC & ADDR_MASK;

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  next_pc;
    pc_src_e          src;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
    logic [XLEN-1:0]  raw_target;
    logic             tgt_mis;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  bad_q, bad_d;
`endif

    pc_target_sel #(
        .XLEN      (XLEN),
        .ADDR_BITS (ADDR_BITS)
    ) u_sel (
        .pc          (pc_q),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .run         (state_q == PC_RUN),
        .br_en       (br_en),
        .br_cond     (br_cond),
        .jal         (jal),
        .jalr        (jalr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4),
`ifdef PC_UNIT_MISALIGN_TRAP_EN
        .raw_target  (raw_target),
        .tgt_mis     (tgt_mis),
`endif
        .src         (src)
    );

    // Next-state logic: redirect beats stall; a bubble only advances the FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
        mis_d   = mis_q;
        bad_d   = bad_q;
`endif
        if (redirect) begin
            pc_d    = next_pc;
            state_d = PC_BUBBLE;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
            mis_d   = 1'b0;
            bad_d   = '0;
`endif
        end else if (!stall) begin
            if (state_q == PC_BUBBLE) begin
                state_d = PC_RUN;
            end else begin
`ifdef PC_UNIT_MISALIGN_TRAP_EN
                if (tgt_mis) begin
                    pc_d    = RST_PC;
                    state_d = PC_BUBBLE;
                    mis_d   = 1'b1;
                    bad_d   = raw_target;
                end else begin
                    pc_d  = next_pc;
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                pc_d  = next_pc;
                cnt_d = cnt_q + CNT_W'(1);
`endif
            end
        end
    end

    // State, PC and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_BUBBLE;
            pc_q    <= RST_PC;
            cnt_q   <= '0;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
            bad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
            bad_q   <= bad_d;
`endif
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = (state_q == PC_RUN);
    assign retire_cnt = cnt_q;
    assign taken      = (state_q == PC_RUN) && !stall && (src != SRC_SEQ);
`ifdef PC_UNIT_MISALIGN_TRAP_EN
    assign misalign   = mis_q;
    assign bad_addr   = bad_q;
`else
    assign misalign   = 1'b0;
    assign bad_addr   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit (RESET_VEC=0x100, ADDR_BITS=16, a narrow
// 6-bit retire counter so its wrap is reachable).
module tb_pc_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst, stall, br_en, br_cond, jal, jalr, redirect;
    logic [XLEN-1:0]  imm, rs1_data, redirect_pc;
    logic [XLEN-1:0]  pc, pc_plus4, bad_addr;
    logic             pc_valid, taken, misalign;
    logic [CNT_W-1:0] retire_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    logic [XLEN-1:0] exp_pc;

    pc_unit #(
        .XLEN      (XLEN),
        .ADDR_BITS (16),
        .RESET_VEC (32'h100),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_en       (br_en),
        .br_cond     (br_cond),
        .jal         (jal),
        .jalr        (jalr),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_valid    (pc_valid),
        .taken       (taken),
        .misalign    (misalign),
        .bad_addr    (bad_addr),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        stall = 0; br_en = 0; br_cond = 0; jal = 0; jalr = 0;
        redirect = 0; imm = '0; rs1_data = '0; redirect_pc = '0;
    endtask

    initial begin
        clear_ctl();
        rst = 1;
        step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_valid", pc_valid, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_bad", bad_addr, 0);
        chk("rst_taken", taken, 0);
        rst = 0;

        // bubble -> run, then sequential fetch
        step();
        chk("run_pc0", pc, 32'h100);
        chk("run_valid", pc_valid, 1);
        chk("run_cnt0", retire_cnt, 0);
        step();
        chk("seq_pc1", pc, 32'h104);
        chk("seq_cnt1", retire_cnt, 1);
        chk("seq_plus4", pc_plus4, 32'h108);
        step();
        chk("seq_pc2", pc, 32'h108);
        chk("seq_cnt2", retire_cnt, 2);
        exp_cnt = 2;

        // taken branch from 0x0FF0
        redirect = 1; redirect_pc = 32'h0FF0;
        step();
        redirect = 0;
        chk("redir_pc", pc, 32'h0FF0);
        chk("redir_valid", pc_valid, 0);
        chk("redir_cnt", retire_cnt, exp_cnt);
        step();
        br_en = 1; br_cond = 1; imm = 32'h20;
        #1;
        chk("br_taken_comb", taken, 1);
        step();
        exp_cnt++;
        chk("br_pc", pc, 32'h1010);
        chk("br_cnt", retire_cnt, exp_cnt);
        clear_ctl();

        // not-taken branch from 0x0FF0
        redirect = 1; redirect_pc = 32'h0FF0;
        step();
        redirect = 0;
        step();
        br_en = 1; br_cond = 0; imm = 32'h20;
        #1;
        chk("brnt_taken_comb", taken, 0);
        step();
        exp_cnt++;
        chk("brnt_pc", pc, 32'h0FF4);
        clear_ctl();

        // jalr beats jal
        jalr = 1; jal = 1; rs1_data = 32'h0001_2345; imm = 32'd4;
        #1;
        chk("jalr_taken", taken, 1);
        step();
        exp_cnt++;
        chk("jalr_pc", pc, 32'h2348);
        chk("jalr_cnt", retire_cnt, exp_cnt);
        chk("jalr_mis", misalign, 0);

        // jalr to a target with bit1 set
        imm = 32'd6;
        step();
        clear_ctl();
`ifdef PC_UNIT_MISALIGN_TRAP_EN
        chk("mis_pc", pc, 32'h100);
        chk("mis_flag", misalign, 1);
        chk("mis_bad", bad_addr, 32'h0001_234A);
        chk("mis_valid", pc_valid, 0);
        chk("mis_cnt", retire_cnt, exp_cnt);
        step();
        chk("mis_sticky", misalign, 1);
        chk("mis_run_pc", pc, 32'h100);
`else
        exp_cnt++;
        chk("nomis_pc", pc, 32'h2348);
        chk("nomis_flag", misalign, 0);
        chk("nomis_bad", bad_addr, 0);
        chk("nomis_cnt", retire_cnt, exp_cnt);
        step();
        exp_cnt++;
        chk("nomis_seq_pc", pc, 32'h234C);
`endif

        // stall at 0x40 holds pc and counter, ignoring a live jal
        redirect = 1; redirect_pc = 32'h40;
        step();
        redirect = 0;
        chk("redir_clr_mis", misalign, 0);
        step();
        chk("stall_start_pc", pc, 32'h40);
        stall = 1; jal = 1; imm = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_taken", taken, 0);
            step();
            chk("stall_pc", pc, 32'h40);
            chk("stall_cnt", retire_cnt, exp_cnt);
        end

        // redirect accepted during stall, low bits cleared
        redirect = 1; redirect_pc = 32'h203;
        step();
        redirect = 0;
        chk("sredir_pc", pc, 32'h200);
        chk("sredir_valid", pc_valid, 0);
        chk("sredir_cnt", retire_cnt, exp_cnt);
        step();
        chk("stall_bubble_valid", pc_valid, 0);
        stall = 0;
        step();
        chk("bubble_jal_ign_pc", pc, 32'h200);
        chk("bubble_jal_valid", pc_valid, 1);
        chk("bubble_jal_cnt", retire_cnt, exp_cnt);
        clear_ctl();

        // sequential wrap at top of 16-bit space; high redirect bits dropped
        redirect = 1; redirect_pc = 32'h1234_FFFC;
        step();
        redirect = 0;
        chk("hi_redir_pc", pc, 32'hFFFC);
        step();
        chk("wrap_plus4", pc_plus4, 32'h0);
        step();
        exp_cnt++;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_cnt", retire_cnt, exp_cnt);

        // run the counter up to its wrap
        exp_pc = 32'h0;
        while (exp_cnt != 63) begin
            step();
            exp_cnt++;
            exp_pc = (exp_pc + 32'd4) & 32'hFFFF;
        end
        chk("cnt_max", retire_cnt, 6'h3F);
        chk("cnt_max_pc", pc, exp_pc);
        step();
        chk("cnt_wrap", retire_cnt, 0);

        // reset mid-run dominates jal
        rst = 1; jal = 1; imm = 32'h40;
        step();
        rst = 0; jal = 0;
        chk("rst2_pc", pc, 32'h100);
        chk("rst2_valid", pc_valid, 0);
        chk("rst2_cnt", retire_cnt, 0);
        chk("rst2_mis", misalign, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
